// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with signs applied in a single FIX cycle.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        RESULT_VALID,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  step;
  logic [2:0]  op;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] hi, lo, mcand;

  logic        sel_valid, accept, in_signed_a, in_signed_b;
  logic        in_a_neg, in_b_neg;
  logic [31:0] in_a_mag, in_b_mag;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;

  always_comb begin
    sel_valid   = (SELECT[1:0] == 2'b10);
    accept      = START && sel_valid && (state == IDLE || state == DONE);
    in_signed_a = (SELECT[4:2] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    in_signed_b = (SELECT[4:2] inside {3'd0, 3'd1, 3'd4, 3'd6});
    in_a_neg    = in_signed_a && DATA1[31];
    in_b_neg    = in_signed_b && DATA2[31];
    in_a_mag    = in_a_neg ? -DATA1 : DATA1;
    in_b_mag    = in_b_neg ? -DATA2 : DATA2;
  end

  // Multiply keeps {hi,lo} as the right-shifting partial product with the
  // multiplier in lo; divide keeps the partial remainder in hi and the
  // dividend/quotient shifting through lo.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    div_trial = {hi, lo[31]} - {1'b0, mcand};
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    // A zero divisor leaves the dividend magnitude in hi, so the remainder
    // falls out naturally; only the quotient needs forcing.
    quo_fix  = b_zero ? '1 : ((a_neg ^ b_neg) ? -lo : lo);
    rem_fix  = a_neg ? -hi : hi;
    unique case (op)
      3'd0:          fix_result = prod_fix[31:0];
      3'd1, 3'd2,
      3'd3:          fix_result = prod_fix[63:32];
      3'd4, 3'd5:    fix_result = quo_fix;
      default:       fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      step         <= '0;
      op           <= '0;
      a_neg        <= 1'b0;
      b_neg        <= 1'b0;
      b_zero       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      mcand        <= '0;
      BUSY         <= 1'b0;
      RESULT_VALID <= 1'b0;
      RESULT       <= '0;
    end else begin
      RESULT_VALID <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= CALC;
            BUSY   <= 1'b1;
            step   <= '0;
            op     <= SELECT[4:2];
            a_neg  <= in_a_neg;
            b_neg  <= in_b_neg;
            b_zero <= (DATA2 == '0);
            hi     <= '0;
            lo     <= SELECT[4] ? in_a_mag : in_b_mag;
            mcand  <= SELECT[4] ? in_b_mag : in_a_mag;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op[2]) begin
            if (!div_trial[32]) begin
              hi <= div_trial[31:0];
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= {hi[30:0], lo[31]};
              lo <= {lo[30:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[32:1];
            lo <= {mul_sum[0], lo[31:1]};
          end
          step <= step + 5'd1;
          if (step == 5'd31) state <= FIX;
        end
        FIX: begin
          RESULT       <= fix_result;
          RESULT_VALID <= 1'b1;
          BUSY         <= 1'b0;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results and accept cycles are queued
// at request time and matched against each RESULT_VALID pulse.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET, START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, RESULT_VALID;
  logic [31:0] RESULT;

  muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY),
    .RESULT_VALID(RESULT_VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    logic [4:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb_, ub;
    logic [63:0] p, ua64, ub64;
    ia = a; ib = b;
    sa = ia; sb_ = ib;
    ub = longint'({32'd0, b});
    ua64 = {32'd0, a}; ub64 = {32'd0, b};
    case (sel[4:2])
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (RESULT_VALID) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq($sformatf("result sel=%b", e.sel), RESULT, e.exp);
        check_eq($sformatf("latency sel=%b", e.sel), cyc - e.acc + 1, 32'd34);
      end
    end
  end

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input bit push);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    if (push) sb.push_back('{model(sel, a, b), cyc + 1, sel});
    @(negedge CLK);
    START = 1'b0; SELECT = $urandom; DATA1 = $urandom; DATA2 = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      if (!BUSY && !RESULT_VALID) break;
      @(negedge CLK);
    end
    if (i == 60) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      if (RESULT_VALID) break;
      @(negedge CLK);
    end
    if (i == 60) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  localparam logic [4:0] MUL = 5'b00010, MULH = 5'b00110, MULHSU = 5'b01010, MULHU = 5'b01110;
  localparam logic [4:0] DIV = 5'b10010, DIVU = 5'b10110, REM = 5'b11010, REMU = 5'b11110;

  logic [4:0]  dir_sel[12] = '{MULH, MULHU, MULHSU, DIV, REM, DIVU, DIV, REMU, DIV, REM, DIVU, REM};
  logic [31:0] dir_a[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
  logic [31:0] dir_b[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                               32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [4:0]  ops[8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};

  initial begin
    int n;
    RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(negedge CLK);
    check_eq("reset_busy", BUSY, 1'b0);
    check_eq("reset_valid", RESULT_VALID, 1'b0);
    check_eq("reset_result", RESULT, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // MUL 7x6 with BUSY width; a START mid-operation must be ignored.
    issue(MUL, 32'd7, 32'd6, 1'b1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!BUSY) break;
      n++;
      START = (i == 4); SELECT = DIV; DATA1 = 32'd100; DATA2 = 32'd3;
      @(negedge CLK);
    end
    START = 1'b0;
    check_eq("mul_busy_cycles", n, 32'd33);
    wait_idle("mul");

    for (int i = 0; i < 12; i++) begin
      issue(dir_sel[i], dir_a[i], dir_b[i], 1'b1);
      wait_idle("directed");
    end

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 6 == 5) b = b >> 20;
      issue(ops[i % 8], a, b, 1'b1);
      wait_idle("random");
    end

    // Back-to-back: new request accepted in the DONE cycle, START held high.
    issue(DIVU, 32'd1000, 32'd7, 1'b1);
    wait_valid("b2b_first");
    START = 1'b1; SELECT = REM; DATA1 = 32'hFFFF_FF00; DATA2 = 32'd9;
    sb.push_back('{model(REM, 32'hFFFF_FF00, 32'd9), cyc + 1, REM});
    @(negedge CLK);
    check_eq("b2b_accept_busy", BUSY, 1'b1);
    repeat (3) @(negedge CLK);
    START = 1'b0;
    wait_idle("b2b");

    // Invalid op codes are ignored.
    START = 1'b1; SELECT = 5'b00000;
    @(negedge CLK);
    check_eq("ignore_00000_busy", BUSY, 1'b0);
    SELECT = 5'b00011;
    @(negedge CLK);
    check_eq("ignore_00011_busy", BUSY, 1'b0);
    START = 1'b0;
    @(negedge CLK);

    // Reset mid-DIV aborts; START alongside RESET is ignored.
    issue(DIV, 32'd12345, 32'd17, 1'b0);
    repeat (9) @(negedge CLK);
    RESET = 1'b1; START = 1'b1; SELECT = MUL; DATA1 = 32'd3; DATA2 = 32'd3;
    @(negedge CLK);
    check_eq("abort_busy", BUSY, 1'b0);
    check_eq("abort_result", RESULT, 32'd0);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    check_eq("abort_no_restart", BUSY, 1'b0);
    repeat (40) @(negedge CLK);

    check_eq("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
